// File: rtl/majority13_pkg.sv
// Shared constants and types for the 13-item majority detector.
// Optional maj_count output is enabled by defining MAJ13_COUNT_OUT_EN.
package majority13_pkg;
  localparam int DATA_W   = 4;
  localparam int N_ITEMS  = 13;
  localparam int THRESH   = (N_ITEMS + 1) / 2;
  localparam int CNT_W    = $clog2(N_ITEMS + 1);
  localparam int N_VALUES = 1 << DATA_W;
  localparam int WORD_W   = N_ITEMS * DATA_W;

  typedef logic [DATA_W-1:0] item_t;
  typedef logic [CNT_W-1:0]  cnt_t;
endpackage

// File: rtl/majority13_vote_if.sv
// Streaming port bundle for majority13_vote; maj_count exists only with MAJ13_COUNT_OUT_EN.
// Handshake: a word is consumed on every rising edge where in_valid=1 (no ready, no
// backpressure); results are qualified by out_valid, and out/maj_value are don't-care otherwise.
interface majority13_vote_if;
  import majority13_pkg::*;

  logic                in_valid;
  logic [WORD_W-1:0]   numbers;
  logic                out_valid;
  logic                out;
  item_t               maj_value;
`ifdef MAJ13_COUNT_OUT_EN
  cnt_t                maj_count;
`endif

  modport master (
    output in_valid, numbers,
`ifdef MAJ13_COUNT_OUT_EN
    input  maj_count,
`endif
    input  out_valid, out, maj_value
  );

  modport slave (
    input  in_valid, numbers,
`ifdef MAJ13_COUNT_OUT_EN
    output maj_count,
`endif
    output out_valid, out, maj_value
  );
endinterface

// File: rtl/majority13_vote_value_counter.sv
// Combinational occurrence counter: how many of the packed items equal VALUE.
module value_counter
  import majority13_pkg::*;
#(
  parameter int VALUE = 0
) (
  input  logic [WORD_W-1:0] i_numbers,
  output cnt_t              o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (i_numbers[i*DATA_W +: DATA_W] == item_t'(VALUE)) begin
        o_count = o_count + cnt_t'(1);
      end
    end
  end

endmodule

// File: rtl/majority13_vote.sv
// Two-stage majority detector over 13 4-bit items: per-value counts, then threshold/encode.
// Define MAJ13_COUNT_OUT_EN to add the maj_count output.
module majority13_vote
  import majority13_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  majority13_vote_if.slave   bus
);

  cnt_t  w_count [N_VALUES];
  cnt_t  r_count [N_VALUES];
  logic  r_valid_s1;

  logic [N_VALUES-1:0] w_hit;
  logic                w_found;
  item_t               w_idx;

  logic  r_out_valid;
  logic  r_out;
  item_t r_maj_value;

  for (genvar v = 0; v < N_VALUES; v++) begin : g_cnt
    value_counter #(.VALUE(v)) u_cnt (
      .i_numbers (bus.numbers),
      .o_count   (w_count[v])
    );
  end

  // Counts are captured every cycle; only the valid bit qualifies them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_s1 <= 1'b0;
      for (int v = 0; v < N_VALUES; v++) r_count[v] <= '0;
    end else begin
      r_valid_s1 <= bus.in_valid;
      for (int v = 0; v < N_VALUES; v++) r_count[v] <= w_count[v];
    end
  end

  // At most one value can reach THRESH; lowest index wins anyway.
  always_comb begin
    w_hit   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int v = 0; v < N_VALUES; v++) begin
      w_hit[v] = (r_count[v] >= cnt_t'(THRESH));
      if (w_hit[v] && !w_found) begin
        w_found = 1'b1;
        w_idx   = item_t'(v);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out       <= 1'b0;
      r_maj_value <= '0;
    end else begin
      r_out_valid <= r_valid_s1;
      r_out       <= |w_hit;
      r_maj_value <= w_idx;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out       = r_out;
  assign bus.maj_value = r_maj_value;

`ifdef MAJ13_COUNT_OUT_EN
  cnt_t w_max;
  cnt_t r_maj_count;

  always_comb begin
    w_max = '0;
    for (int v = 0; v < N_VALUES; v++) begin
      if (r_count[v] > w_max) w_max = r_count[v];
    end
  end

  // With no winner the largest count is reported instead.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_maj_count <= '0;
    end else begin
      r_maj_count <= w_found ? r_count[w_idx] : w_max;
    end
  end

  assign bus.maj_count = r_maj_count;
`endif

endmodule

// File: tb/tb_majority13_vote.sv
// Randomized self-checking bench for majority13_vote against a counting reference model.
module tb_majority13_vote;
  import majority13_pkg::*;

  logic clk;
  logic rst;
  majority13_vote_if bus ();

  majority13_vote dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Expected entry: {valid, out, maj_value[3:0], count[3:0]}
  logic [9:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] model(input logic [WORD_W-1:0] w);
    int cnt[16];
    int best;
    int maj;
    logic [9:0] r;
    for (int v = 0; v < 16; v++) cnt[v] = 0;
    for (int i = 0; i < 13; i++) cnt[int'(w[i*4 +: 4])] += 1;
    best = 0;
    maj  = -1;
    for (int v = 0; v < 16; v++) begin
      if (cnt[v] > best) best = cnt[v];
      if (cnt[v] >= 7 && maj < 0) maj = v;
    end
    r[9] = 1'b1;
    r[8] = (maj >= 0);
    r[7:4] = (maj >= 0) ? 4'(maj) : 4'd0;
    r[3:0] = (maj >= 0) ? 4'(cnt[maj]) : 4'(best);
    return r;
  endfunction

  function automatic logic [WORD_W-1:0] pack13(input int it[13]);
    logic [WORD_W-1:0] w;
    for (int i = 0; i < 13; i++) w[i*4 +: 4] = 4'(it[i]);
    return w;
  endfunction

  task automatic step(input logic v, input logic [WORD_W-1:0] w, input logic r, input string tag);
    logic [9:0] e;
    bus.in_valid = v;
    bus.numbers  = w;
    rst          = r;
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      exp_q.push_back(10'd0);
      e = 10'd0;
    end else begin
      exp_q.push_back(v ? model(w) : 10'd0);
      e = exp_q.pop_front();
    end
    #1;
    if (r) begin
      check_eq({tag, "_rst_valid"}, 32'(bus.out_valid), 0);
      check_eq({tag, "_rst_out"},   32'(bus.out), 0);
      check_eq({tag, "_rst_maj"},   32'(bus.maj_value), 0);
`ifdef MAJ13_COUNT_OUT_EN
      check_eq({tag, "_rst_cnt"},   32'(bus.maj_count), 0);
`endif
    end else begin
      check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'(e[9]));
      if (e[9]) begin
        check_eq({tag, "_out"}, 32'(bus.out), 32'(e[8]));
        check_eq({tag, "_maj"}, 32'(bus.maj_value), 32'(e[7:4]));
`ifdef MAJ13_COUNT_OUT_EN
        check_eq({tag, "_cnt"}, 32'(bus.maj_count), 32'(e[3:0]));
`endif
      end
    end
  endtask

  task automatic drive_items(input int it[13], input string tag);
    step(1'b1, pack13(it), 1'b0, tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, {$urandom, $urandom}, 1'b0, "idle");
  endtask

  initial begin
    int it[13];
    logic [WORD_W-1:0] w;
    int k;
    int mv;

    bus.in_valid = 1'b0;
    bus.numbers  = '0;
    rst          = 1'b1;

    step(1'b0, '0, 1'b1, "reset");
    step(1'b0, '0, 1'b1, "reset2");
    idle(2);

    it = '{12,7,15,12,11,5,8,13,8,2,6,2,3};  drive_items(it, "nomaj0");
    idle(2);
    it = '{12,7,15,2,11,10,8,13,8,2,1,2,3};  drive_items(it, "nomaj1");
    idle(1);
    it = '{13,7,10,6,11,1,0,5,9,2,4,6,7};    drive_items(it, "nomaj2");
    it = '{12,7,15,12,11,10,8,11,9,2,4,2,3}; drive_items(it, "nomaj3");
    idle(1);
    it = '{5,5,1,5,2,5,3,5,4,5,6,5,7};       drive_items(it, "seven5");
    it = '{9,0,9,1,9,2,9,3,9,4,9,5,6};       drive_items(it, "six9");
    it = '{0,0,0,0,0,0,0,0,0,0,0,0,0};       drive_items(it, "all0");
    it = '{15,15,15,15,15,15,15,15,15,15,15,15,15}; drive_items(it, "all15");
    idle(2);

    // Back-to-back with a one-cycle reset after the second word.
    it = '{3,3,3,3,3,3,3,3,1,2,4,5,6};       drive_items(it, "b2b_w1");
    it = '{8,8,8,8,8,8,8,8,8,8,1,2,4};       drive_items(it, "b2b_w2");
    step(1'b0, '0, 1'b1, "b2b_rst");
    it = '{10,10,10,10,10,10,10,1,2,3,4,5,6}; drive_items(it, "b2b_w3");
    it = '{1,2,3,4,5,6,7,8,9,10,11,12,13};   drive_items(it, "b2b_w4");
    idle(3);

    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 13; i++) it[i] = int'($urandom_range(0, 15));
      k  = int'($urandom_range(0, 13));
      mv = int'($urandom_range(0, 15));
      for (int j = 0; j < k; j++) it[$urandom_range(0, 12)] = mv;
      w = pack13(it);
      if ($urandom_range(0, 59) == 0)
        step(1'b0, w, 1'b1, "rnd_rst");
      else
        step(($urandom_range(0, 3) != 0), w, 1'b0, "rnd");
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
